// File: rtl/load_store_unit_if.sv
// Bundles for the load/store unit: the core-facing request/response port
// and the word-wide req/ack data-memory port.
interface lsu_req_if #(parameter int unsigned XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            busy;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, busy, rsp_valid, rsp_rdata, rsp_fault
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, busy, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

interface lsu_mem_if #(parameter int unsigned XLEN = 32);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one byte/half/word load or store per accepted op,
// with lane steering, load extension and fault reporting (misaligned/illegal/timeout).
module load_store_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic        clk,
  input logic        rst_n,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            fault_q, fault_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            acc_illegal, acc_misaligned;
  logic [3:0]      acc_wstrb;
  logic [XLEN-1:0] acc_wdata;
  logic [XLEN-1:0] load_ext;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // Decode of the op presented at the request port (only used on accept).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_illegal    = 1'b0;
    acc_misaligned = 1'b0;
    acc_wstrb      = 4'b0000;
    acc_wdata      = '0;
    if (req.req_we) begin
      acc_illegal = (req.req_funct3 > 3'b010);
    end else begin
      acc_illegal = (req.req_funct3 == 3'b011) || (req.req_funct3 == 3'b110) ||
                    (req.req_funct3 == 3'b111);
    end
    case (req.req_funct3[1:0])
      2'b01:   acc_misaligned = req.req_addr[0];
      2'b10:   acc_misaligned = (req.req_addr[1:0] != 2'b00);
      default: acc_misaligned = 1'b0;
    endcase
    if (req.req_we) begin
      case (req.req_funct3[1:0])
        2'b00: begin
          acc_wstrb = 4'b0001 << req.req_addr[1:0];
          acc_wdata = {4{req.req_wdata[7:0]}};
        end
        2'b01: begin
          acc_wstrb = 4'b0011 << {req.req_addr[1], 1'b0};
          acc_wdata = {2{req.req_wdata[15:0]}};
        end
        default: begin
          acc_wstrb = 4'b1111;
          acc_wdata = req.req_wdata;
        end
      endcase
    end
  end

  // Lane extraction and extension of the returned word, keyed by the registered op.
  always_comb begin
    ld_byte  = mem.mem_rdata[8*addr_q[1:0] +: 8];
    ld_half  = mem.mem_rdata[16*addr_q[1] +: 16];
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req.req_valid) begin
          addr_d   = req.req_addr;
          we_d     = req.req_we;
          funct3_d = req.req_funct3;
          wdata_d  = acc_wdata;
          wstrb_d  = acc_wstrb;
          rdata_d  = '0;
          cnt_d    = '0;
          fault_d  = acc_illegal || acc_misaligned;
          state_d  = (acc_illegal || acc_misaligned) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // An ack in the last allowed cycle still completes without fault.
        if (mem.mem_ack) begin
          if (!we_q) rdata_d = load_ext;
          state_d = S_RESP;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
          fault_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      wdata_q  <= '0;
      wstrb_q  <= 4'b0000;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  logic in_wait, in_resp;
  assign in_wait = (state_q == S_WAIT);
  assign in_resp = (state_q == S_RESP);

  assign req.req_ready = (state_q == S_IDLE);
  assign req.busy      = (state_q != S_IDLE);
  assign req.rsp_valid = in_resp;
  assign req.rsp_rdata = in_resp ? rdata_q : '0;
  assign req.rsp_fault = in_resp && fault_q;

  // Memory outputs are held at zero outside WAIT so reset drops them at once.
  assign mem.mem_req   = in_wait;
  assign mem.mem_we    = in_wait && we_q;
  assign mem.mem_addr  = in_wait ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem.mem_wdata = in_wait ? wdata_q : '0;
  assign mem.mem_wstrb = in_wait ? wstrb_q : 4'b0000;

endmodule
